// File: rtl/ioctl_sdram_packer_if.sv
// Bus bundle between the data_io download port, the packer and SDRAM port.
// master: download source + SDRAM ack side; slave: ioctl_sdram_packer.
interface ioctl_sdram_packer_if #(
    parameter int AW = 25
);
    logic          ioctl_downl;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic [AW-1:0] sdr_addr;
    logic [15:0]   sdr_data;
    logic [1:0]    sdr_be;
    logic          sdr_req;
    logic          sdr_ack;
    logic          busy;
    logic          done;
    logic          overflow;

    modport master (
        output ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
        input  ioctl_wait, sdr_addr, sdr_data, sdr_be, sdr_req,
        input  busy, done, overflow
    );

    modport slave (
        input  ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
        output ioctl_wait, sdr_addr, sdr_data, sdr_be, sdr_req,
        output busy, done, overflow
    );
endinterface

// File: rtl/ioctl_sdram_packer.sv
// Packs the ioctl byte stream into 16-bit words with byte enables,
// buffers them in a FIFO and drains them with a toggle req/ack handshake.
// Ports: clk_sys, reset (async, active high), bus (slave modport):
//   ioctl_* download side, sdr_* SDRAM request side, busy/done/overflow.
module ioctl_sdram_packer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int AW          = 25,
    parameter int WAIT_MARGIN = 2
) (
    input logic                 clk_sys,
    input logic                 reset,
    ioctl_sdram_packer_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int PW = LW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] MARGIN_P = PW'(WAIT_MARGIN);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } word_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // Pending even byte
    logic          pb_valid;
    logic [AW-1:0] pb_addr;
    logic [7:0]    pb_data;

    // FIFO
    word_t         mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_1;
    logic [PW-1:0] count;
    logic [PW-1:0] free;
    logic [PW-1:0] room;
    logic          empty;
    word_t         head;

    // Engine
    state_t        state;
    state_t        state_n;
    logic          pop;
    logic          ack_s1;
    logic          ack_s2;
    logic          req_q;
    word_t         out_q;

    // Status
    logic          downl_q;
    logic          rise;
    logic          fall;
    logic          wait_q;
    logic          done_q;
    logic          armed;
    logic          ovf_q;
    logic          busy_c;

    // Packer decode
    logic          odd;
    logic          match;
    logic [AW-1:0] addr_even;
    word_t         flush_w;
    word_t         full_w;
    word_t         half_w;
    word_t         w0;
    word_t         w1;
    logic [1:0]    need;
    logic [1:0]    n_push;
    logic          fits;
    logic          pb_load;
    logic          pb_clear;
    logic          drop;

    assign wptr_1 = wptr + PW'(1);
    assign count  = wptr - rptr;
    assign free   = DEPTH_P - count;
    assign empty  = (wptr == rptr);
    assign head   = mem[rptr[LW-1:0]];
    // A pop this cycle frees a slot for a push in the same cycle.
    assign room   = free + PW'(pop);

    assign rise = bus.ioctl_downl & ~downl_q;
    assign fall = ~bus.ioctl_downl & downl_q;

    assign odd       = bus.ioctl_addr[0];
    assign addr_even = {bus.ioctl_addr[AW-1:1], 1'b0};
    assign match     = pb_valid &&
                       (pb_addr == bus.ioctl_addr - AW'(1));

    assign flush_w = '{addr: pb_addr,
                       data: {8'h00, pb_data},
                       be:   2'b01};
    assign full_w  = '{addr: addr_even,
                       data: {bus.ioctl_dout, pb_data},
                       be:   2'b11};
    assign half_w  = '{addr: addr_even,
                       data: {bus.ioctl_dout, 8'h00},
                       be:   2'b10};

    always_comb begin
        need     = 2'd0;
        w0       = flush_w;
        w1       = half_w;
        pb_load  = 1'b0;
        pb_clear = 1'b0;
        if (bus.ioctl_wr) begin
            if (!odd) begin
                need    = pb_valid ? 2'd1 : 2'd0;
                pb_load = 1'b1;
            end else if (match) begin
                need     = 2'd1;
                w0       = full_w;
                pb_clear = 1'b1;
            end else if (pb_valid) begin
                need     = 2'd2;
                pb_clear = 1'b1;
            end else begin
                need = 2'd1;
                w0   = half_w;
            end
        end else if (fall && pb_valid) begin
            need     = 2'd1;
            pb_clear = 1'b1;
        end
        fits   = (room >= PW'(need));
        n_push = fits ? need : 2'd0;
        drop   = ~fits;
    end

    // Pending byte: a rejected byte leaves PB untouched, except that a
    // rejected end-of-download flush has nowhere to go and is discarded.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pb_valid <= 1'b0;
            pb_addr  <= '0;
            pb_data  <= '0;
        end else if (fits) begin
            if (pb_load) begin
                pb_valid <= 1'b1;
                pb_addr  <= bus.ioctl_addr;
                pb_data  <= bus.ioctl_dout;
            end else if (pb_clear) begin
                pb_valid <= 1'b0;
            end
        end else if (!bus.ioctl_wr) begin
            pb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (n_push != 2'd0) begin
            mem[wptr[LW-1:0]] <= w0;
        end
        if (n_push == 2'd2) begin
            mem[wptr_1[LW-1:0]] <= w1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + PW'(n_push);
            rptr <= rptr + PW'(pop);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= bus.sdr_ack;
            ack_s2 <= ack_s1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A completed ack in WAIT can launch the next request directly.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_s2 == req_q) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_q <= 1'b0;
            out_q <= '0;
        end else if (pop) begin
            req_q <= ~req_q;
            out_q <= head;
        end
    end

    assign busy_c = pb_valid | ~empty | (state == S_WAIT);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            downl_q <= 1'b0;
            wait_q  <= 1'b0;
            done_q  <= 1'b0;
            armed   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            downl_q <= bus.ioctl_downl;
            wait_q  <= (free <= MARGIN_P);
            done_q  <= 1'b0;
            if (rise) begin
                armed <= 1'b1;
                ovf_q <= 1'b0;
            end else if (armed && !bus.ioctl_downl && !busy_c) begin
                armed  <= 1'b0;
                done_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.sdr_addr   = out_q.addr;
    assign bus.sdr_data   = out_q.data;
    assign bus.sdr_be     = out_q.be;
    assign bus.sdr_req    = req_q;
    assign bus.busy       = busy_c;
    assign bus.done       = done_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_ioctl_sdram_packer.sv
// Directed bench for ioctl_sdram_packer: byte packing, request
// ordering, flow control, overflow, done pulse and mid-run reset.
module tb_ioctl_sdram_packer;
    typedef struct {
        logic [24:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } req_t;

    logic clk;
    logic rst;
    ioctl_sdram_packer_if #(.AW(25)) bus ();

    ioctl_sdram_packer #(
        .FIFO_DEPTH(8), .AW(25), .WAIT_MARGIN(2)
    ) dut (
        .clk_sys(clk),
        .reset  (rst),
        .bus    (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    bit   ack_en = 1;
    logic prev_req = 0;
    int   ack_cnt = 0;
    req_t log_q[$];

    initial clk = 0;
    always #5 clk = ~clk;

    // SDRAM side model: logs each request toggle, returns ack later.
    always @(negedge clk) begin
        if (rst) begin
            bus.sdr_ack = 0;
            prev_req = bus.sdr_req;
            ack_cnt = 0;
        end else begin
            if (bus.sdr_req !== prev_req)
                log_q.push_back('{bus.sdr_addr, bus.sdr_data, bus.sdr_be});
            prev_req = bus.sdr_req;
            if (bus.done === 1'b1) done_cnt++;
            if (ack_en && bus.sdr_ack !== bus.sdr_req) begin
                ack_cnt++;
                if (ack_cnt >= 4) begin
                    bus.sdr_ack = bus.sdr_req;
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ioctl_wr = 1; bus.ioctl_addr = a; bus.ioctl_dout = d;
        @(negedge clk);
        bus.ioctl_wr = 0;
    endtask

    task automatic start_dl();
        log_q.delete();
        done_cnt = 0;
        @(negedge clk); bus.ioctl_downl = 0;
        @(negedge clk); bus.ioctl_downl = 1;
        @(negedge clk);
    endtask

    task automatic end_dl(input int budget);
        int n;
        bus.ioctl_downl = 0;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (done_cnt == 0) begin
            miscompares++;
            $display("FAIL done_timeout: no done pulse in %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        logic [47:0] got;
        got = {bus.sdr_req, bus.busy, bus.done, bus.overflow,
               bus.ioctl_wait, bus.sdr_be, bus.sdr_data, bus.sdr_addr[20:0]};
        vectors++;
        if (got !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
    endtask

    task automatic test_pair();
        logic r0;
        start_dl();
        r0 = bus.sdr_req;
        put_byte(25'd0, 8'hAA);
        put_byte(25'd1, 8'hBB);
        vectors++;
        if (bus.sdr_req !== r0) begin
            miscompares++;
            $display("FAIL pair_req_n1: got %b want %b", bus.sdr_req, r0);
        end
        @(negedge clk);
        vectors++;
        if (bus.sdr_req !== ~r0) begin
            miscompares++;
            $display("FAIL pair_req_n2: got %b want %b", bus.sdr_req, ~r0);
        end
        end_dl(100);
        repeat (10) @(negedge clk);
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL pair_done_once: got %0d want 1", done_cnt);
        end
        vectors++;
        if (log_q.size() != 1 || log_q[0].a !== 25'd0 ||
            log_q[0].d !== 16'hBBAA || log_q[0].be !== 2'b11) begin
            miscompares++;
            $display("FAIL pair_word: got n=%0d %h/%h/%b want 1 0/BBAA/11",
                     log_q.size(), log_q[0].a, log_q[0].d, log_q[0].be);
        end
    endtask

    task automatic test_lone();
        start_dl();
        put_byte(25'd6, 8'h5C);
        end_dl(100);
        vectors++;
        if (bus.sdr_ack !== bus.sdr_req) begin
            miscompares++;
            $display("FAIL lone_done_after_ack: ack %b req %b",
                     bus.sdr_ack, bus.sdr_req);
        end
        vectors++;
        if (log_q.size() != 1 || log_q[0].a !== 25'd6 ||
            log_q[0].d !== 16'h005C || log_q[0].be !== 2'b01) begin
            miscompares++;
            $display("FAIL lone_word: got n=%0d %h/%h/%b want 1 6/005C/01",
                     log_q.size(), log_q[0].a, log_q[0].d, log_q[0].be);
        end
    endtask

    task automatic test_odd();
        start_dl();
        put_byte(25'd9, 8'h77);
        end_dl(100);
        vectors++;
        if (log_q.size() != 1 || log_q[0].a !== 25'd8 ||
            log_q[0].d !== 16'h7700 || log_q[0].be !== 2'b10) begin
            miscompares++;
            $display("FAIL odd_word: got n=%0d %h/%h/%b want 1 8/7700/10",
                     log_q.size(), log_q[0].a, log_q[0].d, log_q[0].be);
        end
    endtask

    task automatic test_skip();
        start_dl();
        put_byte(25'd0, 8'h11);
        put_byte(25'd2, 8'h22);
        put_byte(25'd3, 8'h33);
        end_dl(150);
        vectors++;
        if (log_q.size() != 2) begin
            miscompares++;
            $display("FAIL skip_count: got %0d want 2", log_q.size());
        end else begin
            vectors++;
            if (log_q[0].a !== 25'd0 || log_q[0].d !== 16'h0011 ||
                log_q[0].be !== 2'b01) begin
                miscompares++;
                $display("FAIL skip_w0: got %h/%h/%b want 0/0011/01",
                         log_q[0].a, log_q[0].d, log_q[0].be);
            end
            vectors++;
            if (log_q[1].a !== 25'd2 || log_q[1].d !== 16'h3322 ||
                log_q[1].be !== 2'b11) begin
                miscompares++;
                $display("FAIL skip_w1: got %h/%h/%b want 2/3322/11",
                         log_q[1].a, log_q[1].d, log_q[1].be);
            end
        end
    endtask

    task automatic test_flow();
        int stop_idx;
        int n;
        logic [24:0] ea;
        logic [15:0] ed;
        stop_idx = -1;
        ack_en = 0;
        start_dl();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ioctl_wait === 1'b1 && stop_idx < 0) begin
                stop_idx = i;
                vectors++;
                if (bus.overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flow_no_ovf: got %b want 0", bus.overflow);
                end
            end
            bus.ioctl_wr = 1;
            bus.ioctl_addr = 25'h100 + 25'(i);
            bus.ioctl_dout = 8'h40 + 8'(i);
        end
        @(negedge clk);
        bus.ioctl_wr = 0;
        vectors++;
        if (stop_idx != 15) begin
            miscompares++;
            $display("FAIL flow_wait_point: got %0d want 15", stop_idx);
        end
        @(negedge clk);
        vectors++;
        if (bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL flow_ovf: got %b want 1", bus.overflow);
        end
        ack_en = 1;
        n = 0;
        while (log_q.size() < 9 && n < 300) begin
            @(negedge clk); n++;
        end
        end_dl(100);
        vectors++;
        if (log_q.size() != 10) begin
            miscompares++;
            $display("FAIL flow_count: got %0d want 10", log_q.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                ea = 25'h100 + 25'(2 * k);
                ed = {8'h41 + 8'(2 * k), 8'h40 + 8'(2 * k)};
                vectors++;
                if (log_q[k].a !== ea || log_q[k].d !== ed ||
                    log_q[k].be !== 2'b11) begin
                    miscompares++;
                    $display("FAIL flow_w%0d: got %h/%h/%b want %h/%h/11",
                             k, log_q[k].a, log_q[k].d, log_q[k].be, ea, ed);
                end
            end
            vectors++;
            if (log_q[9].a !== 25'h112 || log_q[9].d !== 16'h0052 ||
                log_q[9].be !== 2'b01) begin
                miscompares++;
                $display("FAIL flow_tail: got %h/%h/%b want 112/0052/01",
                         log_q[9].a, log_q[9].d, log_q[9].be);
            end
        end
    endtask

    task automatic test_reset_mid();
        ack_en = 0;
        start_dl();
        vectors++;
        if (bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_on_rise: got %b want 0", bus.overflow);
        end
        for (int i = 0; i < 8; i++)
            put_byte(25'h200 + 25'(i), 8'h80 + 8'(i));
        repeat (3) @(negedge clk);
        vectors++;
        if (log_q.size() != 1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: got n=%0d busy=%b want 1/1",
                     log_q.size(), bus.busy);
        end
        rst = 1;
        @(negedge clk);
        vectors++;
        if (bus.sdr_req !== 1'b0 || bus.busy !== 1'b0 ||
            bus.ioctl_wait !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: req=%b busy=%b wait=%b want 0/0/0",
                     bus.sdr_req, bus.busy, bus.ioctl_wait);
        end
        rst = 0;
        ack_en = 1;
        bus.ioctl_downl = 0;
        repeat (20) @(negedge clk);
        vectors++;
        if (log_q.size() != 1 || done_cnt != 0 || bus.sdr_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after: n=%0d done=%0d req=%b want 1/0/0",
                     log_q.size(), done_cnt, bus.sdr_req);
        end
    endtask

    initial begin
        rst = 1;
        bus.ioctl_downl = 0;
        bus.ioctl_wr = 0;
        bus.ioctl_addr = 0;
        bus.ioctl_dout = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 0;
        @(negedge clk);
        test_reset();
        test_pair();
        test_lone();
        test_odd();
        test_skip();
        test_flow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
